river_crossing: RTL

RIVER_CROSSING -- requirements
Module: river_crossing

---
 rtl/river_crossing_pkg.sv | 13 +
 rtl/river_crossing_conflict_check.sv | 18 +
 rtl/river_crossing.sv | 97 +++++++++
 3 files changed

// File: rtl/river_crossing_pkg.sv
// river_crossing_pkg: shared state encoding, default predator/prey matrix and popcount helper
// for the river-crossing puzzle engine.
package river_crossing_pkg;
    typedef enum logic [1:0] {PLAY = 2'd0, SOLVED = 2'd1, FAILED = 2'd2} rc_state_e;
    // Item 0 (wolf) eats item 1 (goat), item 1 (goat) eats item 2 (cabbage).
    localparam logic [8:0] RC_CONFLICT_DEFAULT = 9'b000_100_010;
    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) p += 5'(v[i]);
        return p;
    endfunction
endpackage

// File: rtl/river_crossing_conflict_check.sv
// rc_conflict_check: flags a position where some predator/prey pair sits together on the
// bank the person has left. Diagonal matrix bits are ignored.
module rc_conflict_check #(
    parameter int                         N_ITEMS  = 3,
    parameter logic [N_ITEMS*N_ITEMS-1:0] CONFLICT = '0
) (
    input  logic [N_ITEMS-1:0] pos_i,
    input  logic               bank_p_i,
    output logic               eaten_o
);
    always_comb begin
        eaten_o = 1'b0;
        for (int i = 0; i < N_ITEMS; i++)
            for (int j = 0; j < N_ITEMS; j++)
                if (i != j && CONFLICT[i*N_ITEMS+j] && pos_i[i] == pos_i[j] && pos_i[i] != bank_p_i)
                    eaten_o = 1'b1;
    end
endmodule

// File: rtl/river_crossing.sv
// river_crossing: river-crossing puzzle engine with move legality, conflict and budget checks.
// Define RIVER_CROSSING_FORMAL_EN to embed the formal assumptions, assertions and cover.
module river_crossing
    import river_crossing_pkg::*;
#(
    parameter int                         N_ITEMS   = 3,
    parameter int                         BOAT_CAP  = 1,
    parameter int                         MAX_MOVES = 15,
    parameter logic [N_ITEMS*N_ITEMS-1:0] CONFLICT  = RC_CONFLICT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               restart,
    input  logic               move_valid,
    input  logic [N_ITEMS-1:0] sel,
    output logic [N_ITEMS-1:0] bank,
    output logic               bank_p,
    output logic [7:0]         move_cnt,
    output logic [1:0]         state,
    output logic               reject
);
    logic [N_ITEMS-1:0] bank_q, bank_d, bank_n;
    logic               bank_p_q, bank_p_d;
    logic [7:0]         move_cnt_q, move_cnt_d, cnt_n;
    rc_state_e          state_q, state_d;
    logic               reject_q, reject_d;
    logic               armed_q;
    logic               legal, take, eaten, solved_n;

    assign bank_n   = bank_q ^ sel;
    assign cnt_n    = move_cnt_q + 8'(move_cnt_q != 8'hff);
    assign legal    = (popcount(16'(sel)) <= 5'(BOAT_CAP)) &&
                      ((sel & (bank_q ^ {N_ITEMS{bank_p_q}})) == '0);
    // armed_q masks the first edge after reset release so no move lands on it.
    assign take     = move_valid && armed_q && !restart && state_q == PLAY;
    assign solved_n = (&bank_n) && !bank_p_q && !eaten;

    rc_conflict_check #(.N_ITEMS(N_ITEMS), .CONFLICT(CONFLICT)) u_check (
        .pos_i    (bank_n),
        .bank_p_i (~bank_p_q),
        .eaten_o  (eaten)
    );

    always_comb begin
        bank_d     = bank_q;
        bank_p_d   = bank_p_q;
        move_cnt_d = move_cnt_q;
        state_d    = state_q;
        reject_d   = 1'b0;
        if (restart) begin
            bank_d     = '0;
            bank_p_d   = 1'b0;
            move_cnt_d = '0;
            state_d    = PLAY;
        end else if (take && legal) begin
            bank_d     = bank_n;
            bank_p_d   = ~bank_p_q;
            move_cnt_d = cnt_n;
            state_d    = eaten ? FAILED : solved_n ? SOLVED :
                         (cnt_n >= 8'(MAX_MOVES)) ? FAILED : PLAY;
        end else if (take) begin
            reject_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q     <= '0;
            bank_p_q   <= 1'b0;
            move_cnt_q <= '0;
            state_q    <= PLAY;
            reject_q   <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            bank_q     <= bank_d;
            bank_p_q   <= bank_p_d;
            move_cnt_q <= move_cnt_d;
            state_q    <= state_d;
            reject_q   <= reject_d;
            armed_q    <= 1'b1;
        end
    end

    assign bank     = bank_q;
    assign bank_p   = bank_p_q;
    assign move_cnt = move_cnt_q;
    assign state    = state_q;
    assign reject   = reject_q;

`ifdef RIVER_CROSSING_FORMAL_EN
    always_comb if (rst_n && move_valid) assume (legal);
    always_comb if (rst_n && take) assume (!eaten);
    cover property (@(posedge clk) state_q == SOLVED);
    assert property (@(posedge clk) disable iff (!rst_n) move_cnt_q <= 8'(MAX_MOVES));
    assert property (@(posedge clk) disable iff (!rst_n) bank_p_q == move_cnt_q[0]);
`endif
endmodule
